// File: rtl/vmx_acc_drain.sv
// vmx_acc_drain: accumulates column partial sums across K-tiles, requantises and queues results for writeback
module vmx_acc_drain #(
    parameter int SUM_BITLEN = 32,
    parameter int ACC_BITLEN = 48,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic                          in_first,
    input  logic                          in_last,
    input  logic                          simd_mode,
    input  logic [4:0]                    shift,
    input  logic [SUM_BITLEN-1:0]         sum_in,
    input  logic                          clear_err,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [SUM_BITLEN-1:0]         out_data,
    output logic                          out_simd,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          ovf_err,
    output logic                          mode_err,
    output logic                          sat_err
);
    localparam int H = SUM_BITLEN / 2;
    localparam int L = ACC_BITLEN / 2;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = ACC_BITLEN + 1;
    localparam int LW = L + 1;
    typedef enum logic {IDLE, ACC} state_t;
    state_t state;
    logic l_simd;
    logic [4:0] l_shift;
    logic [ACC_BITLEN-1:0] acc;
    logic emit_v;
    logic emit_simd;
    logic [SUM_BITLEN-1:0] emit_data;
    logic [SUM_BITLEN:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic start;
    logic m;
    logic [4:0] sh;
    logic [ACC_BITLEN-1:0] base;
    logic [ACC_BITLEN-1:0] new_acc;
    logic [ACC_BITLEN-1:0] shifted;
    logic [FW-1:0] full_sum;
    logic [LW-1:0] lo_sum;
    logic [LW-1:0] hi_sum;
    logic [L-1:0] lo_sh;
    logic [L-1:0] hi_sh;
    logic [SUM_BITLEN-1:0] res;
    logic acc_sat;
    logic clamp;
    logic pop;
    logic push;
    logic drop;
    logic mode_mis;
    always_comb begin
        start    = state == IDLE || in_first;
        m        = start ? simd_mode : l_simd;
        sh       = start ? shift : l_shift;
        base     = start ? '0 : acc;
        full_sum = {1'b0, base} + FW'(sum_in);
        lo_sum   = {1'b0, base[L-1:0]} + LW'(sum_in[H-1:0]);
        hi_sum   = {1'b0, base[ACC_BITLEN-1:L]} + LW'(sum_in[SUM_BITLEN-1:H]);
        acc_sat  = m ? lo_sum[L] || hi_sum[L] : full_sum[ACC_BITLEN];
        new_acc  = m ? {hi_sum[L] ? {L{1'b1}} : hi_sum[L-1:0], lo_sum[L] ? {L{1'b1}} : lo_sum[L-1:0]}
                     : (full_sum[ACC_BITLEN] ? {ACC_BITLEN{1'b1}} : full_sum[ACC_BITLEN-1:0]);
        shifted  = new_acc >> sh;
        lo_sh    = new_acc[L-1:0] >> sh;
        hi_sh    = new_acc[ACC_BITLEN-1:L] >> sh;
        clamp    = m ? |lo_sh[L-1:H] || |hi_sh[L-1:H] : |shifted[ACC_BITLEN-1:SUM_BITLEN];
        res      = m ? {|hi_sh[L-1:H] ? {H{1'b1}} : hi_sh[H-1:0], |lo_sh[L-1:H] ? {H{1'b1}} : lo_sh[H-1:0]}
                     : (|shifted[ACC_BITLEN-1:SUM_BITLEN] ? {SUM_BITLEN{1'b1}} : shifted[SUM_BITLEN-1:0]);
        out_valid = |fifo_count;
        out_data  = out_valid ? mem[rd_ptr][SUM_BITLEN-1:0] : '0;
        out_simd  = out_valid && mem[rd_ptr][SUM_BITLEN];
        pop       = out_valid && out_ready;
        push      = emit_v && (fifo_count != CW'(FIFO_DEPTH) || pop);
        drop      = emit_v && !push;
        mode_mis  = in_valid && !start && simd_mode != l_simd;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            l_simd     <= 1'b0;
            l_shift    <= '0;
            acc        <= '0;
            emit_v     <= 1'b0;
            emit_simd  <= 1'b0;
            emit_data  <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            ovf_err    <= 1'b0;
            mode_err   <= 1'b0;
            sat_err    <= 1'b0;
        end else begin
            if (in_valid) begin
                if (start) begin
                    l_simd  <= simd_mode;
                    l_shift <= shift;
                end
                acc   <= new_acc;
                state <= in_last ? IDLE : ACC;
            end
            emit_v    <= in_valid && in_last;
            emit_simd <= m;
            emit_data <= res;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
            ovf_err    <= (ovf_err && !clear_err) || drop;
            mode_err   <= (mode_err && !clear_err) || mode_mis;
            sat_err    <= (sat_err && !clear_err) || (in_valid && (acc_sat || (in_last && clamp)));
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {emit_simd, emit_data};
    end
endmodule

// File: tb/tb_vmx_acc_drain.sv
// tb_vmx_acc_drain: directed checks plus randomized beats scored against an arithmetic reference model
module tb_vmx_acc_drain;
    logic clk = 0;
    logic rst_n = 0;
    logic in_valid = 0;
    logic in_first = 0;
    logic in_last = 0;
    logic simd_mode = 0;
    logic [4:0] shift = 0;
    logic [31:0] sum_in = 0;
    logic clear_err = 0;
    logic out_ready = 0;
    logic out_valid;
    logic [31:0] out_data;
    logic out_simd;
    logic [2:0] fifo_count;
    logic ovf_err;
    logic mode_err;
    logic sat_err;
    int n_cmp = 0;
    int n_err = 0;
    bit m_open = 0;
    bit m_simd = 0;
    bit m_sat = 0;
    bit m_merr = 0;
    int m_sh = 0;
    longint m_acc = 0;
    longint m_l0 = 0;
    longint m_l1 = 0;
    logic [32:0] q[$];

    vmx_acc_drain dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
        .simd_mode(simd_mode), .shift(shift), .sum_in(sum_in), .clear_err(clear_err),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_simd(out_simd),
        .fifo_count(fifo_count), .ovf_err(ovf_err), .mode_err(mode_err), .sat_err(sat_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input bit f, input bit l, input bit s, input logic [4:0] sh, input logic [31:0] d);
        @(negedge clk);
        in_valid = 1; in_first = f; in_last = l; simd_mode = s; shift = sh; sum_in = d;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 0; in_first = 0; in_last = 0;
    endtask

    task automatic pop_one();
        out_ready = 1;
        idle();
        out_ready = 0;
    endtask

    task automatic clear_flags();
        clear_err = 1;
        idle();
        clear_err = 0;
    endtask

    // Reference: lanes and full accumulator as plain integers, saturation via min()
    task automatic model_beat(input bit f, input bit l, input bit s, input int sh, input logic [31:0] d);
        longint r0, r1;
        if (!m_open || f) begin
            m_open = 1; m_simd = s; m_sh = sh; m_acc = 0; m_l0 = 0; m_l1 = 0;
        end else if (s != m_simd) m_merr = 1;
        if (m_simd) begin
            m_l0 = m_l0 + longint'(d[15:0]);
            m_l1 = m_l1 + longint'(d[31:16]);
            if (m_l0 > 64'hFF_FFFF) begin m_l0 = 64'hFF_FFFF; m_sat = 1; end
            if (m_l1 > 64'hFF_FFFF) begin m_l1 = 64'hFF_FFFF; m_sat = 1; end
        end else begin
            m_acc = m_acc + longint'(d);
            if (m_acc > 64'hFFFF_FFFF_FFFF) begin m_acc = 64'hFFFF_FFFF_FFFF; m_sat = 1; end
        end
        if (l) begin
            m_open = 0;
            if (m_simd) begin
                r0 = m_l0 >> m_sh;
                r1 = m_l1 >> m_sh;
                if (r0 > 64'hFFFF) begin r0 = 64'hFFFF; m_sat = 1; end
                if (r1 > 64'hFFFF) begin r1 = 64'hFFFF; m_sat = 1; end
                q.push_back({1'b1, r1[15:0], r0[15:0]});
            end else begin
                r0 = m_acc >> m_sh;
                if (r0 > 64'hFFFF_FFFF) begin r0 = 64'hFFFF_FFFF; m_sat = 1; end
                q.push_back({1'b0, r0[31:0]});
            end
        end
    endtask

    task automatic score();
        if (out_valid) begin
            if (q.size() == 0) chk("rnd_spurious", out_valid, 0);
            else begin
                chk("rnd_data", out_data, q[0][31:0]);
                chk("rnd_simd", out_simd, q[0][32]);
                void'(q.pop_front());
            end
        end
    endtask

    initial begin
        idle(); idle();
        rst_n = 1;
        chk("rst_valid", out_valid, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_data", out_data, 0);
        chk("rst_simd", out_simd, 0);
        chk("rst_flags", {ovf_err, mode_err, sat_err}, 0);

        beat(1, 0, 0, 0, 32'h0000_1000);
        beat(0, 1, 0, 0, 32'h0000_0200);
        idle();
        chk("t1_lat1", out_valid, 0);
        idle();
        chk("t1_valid", out_valid, 1);
        chk("t1_data", out_data, 32'h0000_1200);
        chk("t1_simd", out_simd, 0);
        pop_one();
        chk("t1_popped", out_valid, 0);

        beat(1, 0, 1, 4, 32'h0010_FFF0);
        beat(0, 1, 1, 4, 32'h0020_0020);
        idle(); idle();
        chk("t2_data", out_data, 32'h0003_1001);
        chk("t2_simd", out_simd, 1);
        chk("t2_sat", sat_err, 0);
        pop_one();

        beat(1, 0, 0, 0, 32'hFFFF_FFFF);
        beat(0, 0, 0, 0, 32'hFFFF_FFFF);
        beat(0, 1, 0, 0, 32'hFFFF_FFFF);
        idle(); idle();
        chk("t3_data_clamp", out_data, 32'hFFFF_FFFF);
        chk("t3_sat", sat_err, 1);
        pop_one();
        clear_flags();
        chk("t3_cleared", sat_err, 0);
        beat(1, 0, 0, 2, 32'hFFFF_FFFF);
        beat(0, 0, 0, 2, 32'hFFFF_FFFF);
        beat(0, 1, 0, 2, 32'hFFFF_FFFF);
        idle(); idle();
        chk("t3_data_shift", out_data, 32'hBFFF_FFFF);
        chk("t3_nosat", sat_err, 0);
        pop_one();

        for (int i = 1; i <= 5; i++) beat(1, 1, 0, 0, 32'(i));
        idle(); idle();
        chk("t4_count_full", fifo_count, 4);
        chk("t4_ovf", ovf_err, 1);
        chk("t4_head", out_data, 1);
        beat(1, 1, 0, 0, 32'd6);
        idle();
        out_ready = 1;
        idle();
        out_ready = 0;
        chk("t4_pushpop_count", fifo_count, 4);
        for (int i = 0; i < 4; i++) begin
            chk("t4_drain_valid", out_valid, 1);
            chk("t4_drain_data", out_data, (i == 3) ? 6 : i + 2);
            pop_one();
        end
        chk("t4_empty", fifo_count, 0);

        clear_flags();
        beat(1, 0, 1, 0, 32'h0000_FFF0);
        beat(0, 1, 0, 0, 32'h0000_FFF0);
        idle(); idle();
        chk("t5_mode_err", mode_err, 1);
        chk("t5_data", out_data, 32'h0000_FFFF);
        chk("t5_simd", out_simd, 1);
        pop_one();

        beat(1, 0, 0, 0, 32'd100);
        beat(1, 1, 0, 0, 32'd5);
        idle(); idle();
        chk("restart_data", out_data, 5);
        pop_one();

        beat(1, 1, 0, 0, 32'd7);
        beat(1, 1, 0, 0, 32'd8);
        beat(1, 0, 0, 0, 32'd9);
        beat(0, 0, 1, 0, 32'd1);
        idle(); idle();
        chk("t6_count_pre", fifo_count, 2);
        rst_n = 0;
        idle();
        rst_n = 1;
        chk("t6_valid", out_valid, 0);
        chk("t6_count", fifo_count, 0);
        chk("t6_flags", {ovf_err, mode_err, sat_err}, 0);
        beat(0, 1, 0, 0, 32'h55);
        idle(); idle();
        chk("t6_fresh", out_data, 32'h55);
        pop_one();

        m_sat = 0; m_merr = 0; m_open = 0;
        out_ready = 1;
        for (int c = 0; c < 500; c++) begin
            bit v, f, l, s;
            int sh, sel;
            logic [31:0] d;
            @(negedge clk);
            score();
            v = $urandom_range(0, 9) < 7;
            f = $urandom_range(0, 3) == 0;
            l = $urandom_range(0, 9) < 3;
            s = ($urandom_range(0, 7) == 0) ? !simd_mode : simd_mode;
            sh = $urandom_range(0, 12);
            sel = $urandom_range(0, 3);
            d = (sel == 0) ? 32'hFFFF_FFFF : (sel == 1) ? 32'($urandom_range(0, 255)) : $urandom;
            in_valid = v; in_first = f; in_last = l; simd_mode = s; shift = 5'(sh); sum_in = d;
            if (v) model_beat(f, l, s, sh, d);
        end
        for (int c = 0; c < 4; c++) begin
            idle();
            score();
        end
        chk("rnd_drained", q.size(), 0);
        chk("rnd_sat", sat_err, m_sat);
        chk("rnd_mode", mode_err, m_merr);
        chk("rnd_ovf", ovf_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
